wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back stage and architectural register file, the consumer end of the MEM/WB pipeline latch.
- Takes the latch outputs, selects ALU result or memory data, and commits the value to a 32-entry register file.
- Serves two combinational read ports to the ID stage and one debug read port.
- Keeps a committed-write counter for debug and verification.

Parameters:
DATA_WIDTH, 32, width of each register and of the write-back data.
REG_ADDR_WIDTH, 5, register address width; the file has 2**REG_ADDR_WIDTH entries.
COUNT_WIDTH, 32, width of the committed-write counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
alu_result_in  in  DATA_WIDTH  ALU result from MEM/WB.
read_data_in  in  DATA_WIDTH  memory load data from MEM/WB.
write_register_in  in  REG_ADDR_WIDTH  destination register from MEM/WB.
reg_write_in  in  1  write enable from MEM/WB (1 = write).
mem_to_reg_in  in  1  source select from MEM/WB (0 = ALU, 1 = memory).
rs_addr  in  REG_ADDR_WIDTH  ID read port A address.
rt_addr  in  REG_ADDR_WIDTH  ID read port B address.
dbg_addr  in  REG_ADDR_WIDTH  debug read port address.
rs_data  out  DATA_WIDTH  read port A data.
rt_data  out  DATA_WIDTH  read port B data.
dbg_data  out  DATA_WIDTH  debug read data; never bypassed, shows committed state only.
wb_data  out  DATA_WIDTH  selected write-back value, combinational.
wb_count  out  COUNT_WIDTH  number of committed writes since reset.

Behaviour:
- wb_data = mem_to_reg_in ? read_data_in : alu_result_in. Purely combinational.
- Commit condition: reg_write_in == 1 and write_register_in != 0.
  - On a rising edge with the commit condition true: regs[write_register_in] <= wb_data, and wb_count <= wb_count + 1.
  - The counter wraps modulo 2**COUNT_WIDTH and does not saturate.
- Register 0:
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded and do not increment wb_count.
- Reads: rs_data, rt_data and dbg_data are combinational from the current array contents.
  - Latency 0 from address change.
  - A committed write becomes visible on the cycle after its clock edge.
- Same-cycle write and read of the same register: governed by WB_BYPASS_EN (see Optional Feature).
- rs_addr == rt_addr: both ports return identical data.
- Reset (reset == 0), asynchronous and effective immediately, including mid-operation:
  - All registers are cleared to 0 and wb_count is cleared to 0.
  - rs_data, rt_data and dbg_data read 0 for every address.
  - wb_data still follows its inputs.
  - No write commits while reset is asserted.
- Reset release: the first commit can occur on the first rising edge with reset == 1.
- X or unknown on reg_write_in must not corrupt state. Bench asserts no X on reg_write_in after reset.
- No stall or flush inputs: the MEM/WB latch already squashes by clearing reg_write.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: write-then-read bypass on read ports A and B.
  - Applies when the commit condition is true and rs_addr/rt_addr == write_register_in.
  - The port returns wb_data in the same cycle, so the ID stage sees the value being written back.
  - dbg_data is never bypassed.
- Not defined: ports return the old array contents until after the edge. The hazard unit must then stall one extra cycle.

Test Plan:
1. Reset = 0 with random inputs, then release -> all three read ports return 0 for addresses 0..31; wb_count = 0.
2. reg_write=1, dest=5, mem_to_reg=0, alu=0xDEADBEEF; one edge -> dbg_addr=5 returns 0xDEADBEEF; wb_count = 1.
3. reg_write=1, dest=0, alu=0x12345678 -> reads of r0 return 0; wb_count unchanged.
4. reg_write=1, dest=7, mem_to_reg=1, read_data=0xCAFEF00D, alu=0x11111111, rs_addr=7 before the edge:
   - with WB_BYPASS_EN: rs_data = 0xCAFEF00D;
   - without WB_BYPASS_EN: rs_data = the old value;
   - in both cases dbg_data = old value before the edge and 0xCAFEF00D after it.
5. reg_write=0 with dest=3 for 10 cycles -> r3 unchanged; wb_count unchanged.
6. Commit to r9 = 0xA5A5A5A5, then drive reset low asynchronously mid-cycle -> r9 and wb_count read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage and architectural register file. This is the consumer end
// of the MEM/WB pipeline latch. It chooses between the ALU result and the
// memory load data, then commits the chosen value to a register file with
// 2**REG_ADDR_WIDTH entries. Register 0 always reads as zero.
//
// The block provides two combinational read ports for the ID stage, one
// debug read port that shows committed state only, and a counter of
// committed writes.
//
// Optional feature (compile-time macro WB_BYPASS_EN):
//   When the macro is defined, read ports A and B forward wb_data whenever
//   the value being written back targets the address they are reading. The
//   debug port never forwards.
//   When the macro is undefined, the read ports return the array contents as
//   they were before the edge.
//
// Ports:
//   clk               in   clock; all state updates on the rising edge
//   reset             in   asynchronous active-low reset
//   alu_result_in     in   ALU result from MEM/WB
//   read_data_in      in   memory load data from MEM/WB
//   write_register_in in   destination register from MEM/WB
//   reg_write_in      in   write enable from MEM/WB
//   mem_to_reg_in     in   source select (0 = ALU, 1 = memory)
//   rs_addr, rt_addr  in   ID read port addresses
//   dbg_addr          in   debug read port address
//   rs_data, rt_data  out  ID read port data
//   dbg_data          out  committed contents at dbg_addr
//   wb_data           out  selected write-back value (combinational)
//   wb_count          out  committed writes since reset (wraps)
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     read_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
    input  logic                      reg_write_in,
    input  logic                      mem_to_reg_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     rs_data,
    output logic [DATA_WIDTH-1:0]     rt_data,
    output logic [DATA_WIDTH-1:0]     dbg_data,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [COUNT_WIDTH-1:0]    wb_count
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
    logic [COUNT_WIDTH-1:0] r_wb_count;

    logic [DATA_WIDTH-1:0]  w_wb_data;
    logic                   w_commit;
    logic [DATA_WIDTH-1:0]  w_rs_array;
    logic [DATA_WIDTH-1:0]  w_rt_array;

    assign w_wb_data = mem_to_reg_in ? read_data_in : alu_result_in;

    // The commit condition is qualified by reset. While reset is asserted,
    // this keeps the bypass path from exposing wb_data on the read ports.
    // If reg_write_in is unknown, the conditional below evaluates false, so
    // an X cannot write into the array.
    assign w_commit = reset && reg_write_in && (write_register_in != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[write_register_in] <= w_wb_data;
            r_wb_count                <= r_wb_count + COUNT_WIDTH'(1);
        end
    end

    // Entry 0 is never written, but the read path still forces zero for
    // address 0 so that the zero register does not depend on that.
    assign w_rs_array = (rs_addr  == '0) ? '0 : r_regs[rs_addr];
    assign w_rt_array = (rt_addr  == '0) ? '0 : r_regs[rt_addr];
    assign dbg_data   = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

`ifdef WB_BYPASS_EN
    // Forward the in-flight write so the ID stage does not need an extra
    // stall cycle for a read of the register being written back.
    assign rs_data = (w_commit && (rs_addr == write_register_in)) ? w_wb_data : w_rs_array;
    assign rt_data = (w_commit && (rt_addr == write_register_in)) ? w_wb_data : w_rt_array;
`else
    assign rs_data = w_rs_array;
    assign rt_data = w_rt_array;
`endif

    assign wb_data  = w_wb_data;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed testbench for wb_regfile, using hand-computed expected values.
// Inputs change on the falling clock edge. Combinational outputs are sampled
// #1 after an input change, and registered state is sampled #1 after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result_in;
    logic [31:0] read_data_in;
    logic [4:0]  write_register_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] dbg_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .COUNT_WIDTH    (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_result_in     (alu_result_in),
        .read_data_in      (read_data_in),
        .write_register_in (write_register_in),
        .reg_write_in      (reg_write_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .dbg_addr          (dbg_addr),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .dbg_data          (dbg_data),
        .wb_data           (wb_data),
        .wb_count          (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outside reset, the write enable must always be a known value.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            assert (!$isunknown(reg_write_in))
                else $error("reg_write_in unknown after reset");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Set up one write-back transaction. The transaction commits on the
    // next rising edge if reg_write is 1.
    task automatic drive_wb(input logic we, input logic [4:0] dest, input logic sel,
                            input logic [31:0] alu, input logic [31:0] mem);
        reg_write_in      = we;
        write_register_in = dest;
        mem_to_reg_in     = sel;
        alu_result_in     = alu;
        read_data_in      = mem;
    endtask

    // Wait for the rising edge, then deassert write so that exactly one
    // commit happens.
    task automatic edge_and_idle();
        @(posedge clk);
        #1;
        reg_write_in = 1'b0;
    endtask

    logic [31:0] old_r7;

    initial begin
        reset    = 1'b0;
        rs_addr  = 5'd0;
        rt_addr  = 5'd0;
        dbg_addr = 5'd0;
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        // ---- 1: reset with random traffic, then release ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_wb(1'b1, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom);
            rs_addr = write_register_in;
            rt_addr = write_register_in;
            #1;
            check("rst_rs_zero", rs_data, 32'h0);
            check("rst_rt_zero", rt_data, 32'h0);
            check("rst_wb_follows", wb_data,
                  mem_to_reg_in ? read_data_in : alu_result_in);
        end
        @(posedge clk);
        #1;
        check("rst_count_held", wb_count, 32'h0);

        @(negedge clk);
        drive_wb(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            rs_addr  = 5'(a);
            rt_addr  = 5'(a);
            dbg_addr = 5'(a);
            #1;
            check($sformatf("init_rs_r%0d", a), rs_data, 32'h0);
            check($sformatf("init_rt_r%0d", a), rt_data, 32'h0);
            check($sformatf("init_dbg_r%0d", a), dbg_data, 32'h0);
        end
        check("init_count", wb_count, 32'h0);

        // ---- 2: ALU write to r5 ----
        @(negedge clk);
        drive_wb(1'b1, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0BADF00D);
        dbg_addr = 5'd5;
        #1;
        check("wb_sel_alu", wb_data, 32'hDEADBEEF);
        check("r5_before_edge", dbg_data, 32'h0);
        edge_and_idle();
        check("r5_after_edge", dbg_data, 32'hDEADBEEF);
        check("count_after_r5", wb_count, 32'd1);

        // ---- 3: a write to r0 is discarded ----
        @(negedge clk);
        drive_wb(1'b1, 5'd0, 1'b0, 32'h12345678, 32'h0);
        rs_addr  = 5'd0;
        dbg_addr = 5'd0;
        #1;
        check("r0_rs_no_bypass", rs_data, 32'h0);
        edge_and_idle();
        check("r0_rs_zero", rs_data, 32'h0);
        check("r0_dbg_zero", dbg_data, 32'h0);
        check("count_r0_unchanged", wb_count, 32'd1);

        // ---- 4: memory write to r7, with a same-cycle read ----
        old_r7 = 32'h0;
        @(negedge clk);
        drive_wb(1'b1, 5'd7, 1'b1, 32'h11111111, 32'hCAFEF00D);
        rs_addr  = 5'd7;
        rt_addr  = 5'd7;
        dbg_addr = 5'd7;
        #1;
        check("wb_sel_mem", wb_data, 32'hCAFEF00D);
`ifdef WB_BYPASS_EN
        check("r7_rs_bypass", rs_data, 32'hCAFEF00D);
        check("r7_rt_bypass", rt_data, 32'hCAFEF00D);
`else
        check("r7_rs_old", rs_data, old_r7);
        check("r7_rt_old", rt_data, old_r7);
`endif
        check("r7_dbg_old", dbg_data, old_r7);
        edge_and_idle();
        check("r7_dbg_new", dbg_data, 32'hCAFEF00D);
        check("r7_rs_new", rs_data, 32'hCAFEF00D);
        check("r7_rt_same", rt_data, 32'hCAFEF00D);
        check("count_after_r7", wb_count, 32'd2);

        // r5 still holds its value, and port B reads a different register.
        rt_addr = 5'd5;
        #1;
        check("r5_rt_retained", rt_data, 32'hDEADBEEF);

        // ---- 5: reg_write low with dest r3 for 10 cycles ----
        @(negedge clk);
        drive_wb(1'b0, 5'd3, 1'b0, 32'h33333333, 32'h44444444);
        rs_addr  = 5'd3;
        dbg_addr = 5'd3;
        #1;
        check("r3_no_bypass_when_idle", rs_data, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("r3_unchanged", dbg_data, 32'h0);
        check("count_idle_unchanged", wb_count, 32'd2);

        // ---- 6: asynchronous reset in the middle of a cycle ----
        @(negedge clk);
        drive_wb(1'b1, 5'd9, 1'b0, 32'hA5A5A5A5, 32'h0);
        dbg_addr = 5'd9;
        rs_addr  = 5'd9;
        edge_and_idle();
        check("r9_committed", dbg_data, 32'hA5A5A5A5);
        check("count_after_r9", wb_count, 32'd3);
        #2;                      // 3 ns after the edge, clock still high
        reset = 1'b0;
        #1;
        check("async_r9_cleared", dbg_data, 32'h0);
        check("async_rs_cleared", rs_data, 32'h0);
        check("async_count_cleared", wb_count, 32'h0);

        // A write presented while reset is asserted must not commit.
        drive_wb(1'b1, 5'd9, 1'b0, 32'h5A5A5A5A, 32'h0);
        #1;
        check("rst_no_bypass_r9", rs_data, 32'h0);
        @(posedge clk);
        #1;
        check("rst_no_commit_r9", dbg_data, 32'h0);
        check("rst_no_commit_count", wb_count, 32'h0);

        // The first rising edge after release commits.
        @(negedge clk);
        reset = 1'b1;
        edge_and_idle();
        check("post_rst_r9", dbg_data, 32'h5A5A5A5A);
        check("post_rst_count", wb_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
